axi4_slave_write_ctrl: RTL and testbench
========================================

// Module: axi4_slave_write_ctrl
// PURPOSE
//  AXI4 slave-side write path: accepts one AW burst, takes W beats, writes a byte memory, returns one B response.
//  Consumes awburst_e/awsize_e/bresp_e encodings; sits downstream of the master write channels (AW/W in, B out).
//  Single outstanding transaction. A side debug port reads memory back for the bench.
// PARAMETERS
//  ADDRESS_WIDTH  32  AW address width
//  DATA_WIDTH     32  W data width (8..128, power of 2); DATA_BYTES = DATA_WIDTH/8
//  MEM_ADDR_BITS  12  memory size = 2**MEM_ADDR_BITS bytes; addresses at/above this give DECERR
// PORTS
//  aclk        in   1                clock, all logic on rising edge
//  aresetn     in   1                asynchronous active-low reset
//  awid        in   16               write address ID
//  awaddr      in   ADDRESS_WIDTH    start address
//  awlen       in   8                beats-1
//  awsize      in   3                bytes/beat = 1<<awsize
//  awburst     in   2                00 FIXED, 01 INCR, 10 WRAP, 11 RESERVED
//  awvalid     in   1                AW valid
//  awready     out  1                AW ready
//  wdata       in   DATA_WIDTH       write data
//  wstrb       in   DATA_BYTES       byte strobes
//  wlast       in   1                last beat
//  wvalid      in   1                W valid
//  wready      out  1                W ready
//  bid         out  16               response ID (= captured awid)
//  bresp       out  2                00 OKAY, 10 SLVERR, 11 DECERR (EXOKAY never driven)
//  bvalid      out  1                B valid
//  bready      in   1                B ready
//  dbg_addr    in   MEM_ADDR_BITS    debug byte address
//  dbg_rdata   out  8                mem[dbg_addr], combinational
// BEHAVIOUR
//  Reset (aresetn=0, async): state IDLE; awready=0, wready=0, bvalid=0, bid=0, bresp=0; memory contents NOT cleared.
//  All handshake outputs registered; awready=1 from first clock edge after aresetn deasserts.
//  FSM: IDLE --(awvalid&awready)--> DATA --(wvalid&wready&beat==awlen)--> RESP --(bvalid&bready)--> IDLE.
//   IDLE: awready=1, wready=0; on AW handshake capture id/addr/len/size/burst, beat=0, err=OKAY, awready->0, wready->1.
//   DATA: wready=1; each W handshake = one beat; beat counter 8-bit, 0..awlen.
//   RESP: wready=0, bvalid=1, bid/bresp stable until bready; bvalid->0 and awready->1 the cycle after handshake.
//  Min latency: AW hs cycle N, first W hs N+1, B valid the cycle after the last W hs.
//  Beat address: size=1<<awsize; FIXED: addr constant; INCR: next = (addr & ~(size-1)) + size;
//   WRAP: total=size*(awlen+1), lower=(start/total)*total; next=addr+size, if next==lower+total then next=lower.
//  Write: for lane i (0..DATA_BYTES-1) with wstrb[i]=1: mem[(addr & ~(DATA_BYTES-1)) + i] <= wdata[8i+7:8i]; wstrb honoured as given.
//  Errors (sticky; first error sets bresp, later ones ignored); on any error no further memory writes for the burst:
//   awburst=RESERVED -> SLVERR; awsize > log2(DATA_BYTES) -> SLVERR;
//   any beat address >= 2**MEM_ADDR_BITS -> DECERR (that beat and subsequent ones not written);
//   wlast=1 on beat<awlen, or wlast=0 on beat==awlen -> SLVERR; burst still ends on beat count, never on wlast.
//  Boundary: awlen=0 single beat; 256-beat INCR counter must not wrap early; INCR crossing 4KB not checked (master's job).
//  Simultaneous: awvalid ignored outside IDLE; wvalid ignored outside DATA (wready=0). B hs in RESP and new AW cannot
//   coincide (awready=0 in RESP).
//  Reset mid-burst: transaction abandoned, no B issued, partial writes remain in memory.
// CONFIGURATION
//  AXI4_WRAP_LEGAL_CHECK_EN defined: WRAP with awlen not in {1,3,7,15}, or start addr not size-aligned -> SLVERR, no writes.
//  Undefined: no WRAP legality check; WRAP uses formula above for any awlen (total may be non-power-of-2), writes performed.
// TESTING
//  1 INCR: awaddr=0x100,len=3,size=2,wdata=0x11223344+k,wstrb=F -> mem[0x100..0x10F] written LE, bresp=00, bid=awid.
//  2 WRAP: awaddr=0x108,len=3,size=2 -> beat addrs 0x108,0x10C,0x100,0x104; bresp=00.
//  3 FIXED+strobe: awaddr=0x200,len=2,wstrb=1,2,4 -> mem[0x200..0x202] get byte lanes 0,1,2 of beats 0,1,2.
//  4 DECERR: awaddr=0xFFC,len=1,size=2 -> beat0 written, beat1 (0x1000) dropped, bresp=11.
//  5 SLVERR: awburst=11 -> all W accepted, no writes, bresp=10; wlast on beat1 of len=3 -> bresp=10.
//  6 Backpressure/reset: hold bready=0 10 cycles -> bvalid,bid,bresp stable; aresetn low mid-DATA -> outputs 0, next AW accepted.

Source files
------------

// File: rtl/axi4_slave_write_ctrl.sv
// AXI4 slave write path: one AW burst, W beats into a byte memory, one B response.
// Single outstanding transaction; a side debug port reads the memory back.
// Optional feature: define AXI4_WRAP_LEGAL_CHECK_EN to reject WRAP bursts whose
// length is not 2/4/8/16 beats or whose start address is not size-aligned.
module axi4_slave_write_ctrl #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_ADDR_BITS = 12
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [15:0]                awid,
    input  logic [ADDRESS_WIDTH-1:0]   awaddr,
    input  logic [7:0]                 awlen,
    input  logic [2:0]                 awsize,
    input  logic [1:0]                 awburst,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic                       wlast,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [15:0]                bid,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [MEM_ADDR_BITS-1:0]   dbg_addr,
    output logic [7:0]                 dbg_rdata
);

    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
    localparam int unsigned MAX_SIZE   = $clog2(DATA_BYTES);
    localparam int unsigned MEM_BYTES  = 2 ** MEM_ADDR_BITS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RESV  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t                     state;
    logic [ADDRESS_WIDTH-1:0]   cur_addr;
    logic [ADDRESS_WIDTH-1:0]   wrap_lower;
    logic [ADDRESS_WIDTH-1:0]   wrap_upper;
    logic [7:0]                 len_q;
    logic [7:0]                 beat_q;
    logic [2:0]                 size_q;
    logic [1:0]                 burst_q;
    logic [1:0]                 err_q;

    logic [7:0]                 mem [MEM_BYTES];

    logic [ADDRESS_WIDTH-1:0]   aw_size_bytes_c;
    logic [ADDRESS_WIDTH-1:0]   aw_total_c;
    logic [ADDRESS_WIDTH-1:0]   aw_lower_c;
    logic [1:0]                 aw_err_c;
    logic [ADDRESS_WIDTH-1:0]   size_bytes_c;
    logic [ADDRESS_WIDTH-1:0]   next_addr_c;
    logic [ADDRESS_WIDTH-1:0]   wrap_step_c;
    logic                       w_hs_c;
    logic                       last_beat_c;
    logic                       addr_oob_c;
    logic [1:0]                 beat_err_c;
    logic                       mem_we_c;
    logic [MEM_ADDR_BITS-1:0]   mem_base_c;

    // Burst geometry and request-level error classification at AW time
    always_comb begin
        aw_size_bytes_c = ADDRESS_WIDTH'(1) << awsize;
        aw_total_c      = aw_size_bytes_c * (ADDRESS_WIDTH'(awlen) + ADDRESS_WIDTH'(1));
        aw_lower_c      = (awaddr / aw_total_c) * aw_total_c;
        aw_err_c        = RESP_OKAY;
        if (awburst == BURST_RESV || 32'(awsize) > MAX_SIZE) begin
            aw_err_c = RESP_SLVERR;
        end
`ifdef AXI4_WRAP_LEGAL_CHECK_EN
        if (aw_err_c == RESP_OKAY && awburst == BURST_WRAP) begin
            if (!(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                (awaddr & (aw_size_bytes_c - ADDRESS_WIDTH'(1))) != '0) begin
                aw_err_c = RESP_SLVERR;
            end
        end
`endif
    end

    // Per-beat address advance and error accumulation
    always_comb begin
        size_bytes_c = ADDRESS_WIDTH'(1) << size_q;
        wrap_step_c  = cur_addr + size_bytes_c;
        case (burst_q)
            BURST_INCR:  next_addr_c = (cur_addr & ~(size_bytes_c - ADDRESS_WIDTH'(1))) + size_bytes_c;
            BURST_WRAP:  next_addr_c = (wrap_step_c == wrap_upper) ? wrap_lower : wrap_step_c;
            BURST_FIXED: next_addr_c = cur_addr;
            default:     next_addr_c = cur_addr;
        endcase

        w_hs_c      = (state == ST_DATA) && wvalid && wready;
        last_beat_c = (beat_q == len_q);
        addr_oob_c  = (cur_addr >> MEM_ADDR_BITS) != '0;
        beat_err_c  = err_q;
        if (err_q == RESP_OKAY) begin
            if (addr_oob_c) begin
                beat_err_c = RESP_DECERR;
            end else if (wlast != last_beat_c) begin
                beat_err_c = RESP_SLVERR;
            end
        end
        mem_we_c   = w_hs_c && (beat_err_c == RESP_OKAY);
        mem_base_c = cur_addr[MEM_ADDR_BITS-1:0] & ~MEM_ADDR_BITS'(DATA_BYTES - 1);
    end

    // Transaction FSM with registered handshake outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bid        <= '0;
            bresp      <= RESP_OKAY;
            cur_addr   <= '0;
            wrap_lower <= '0;
            wrap_upper <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            size_q     <= '0;
            burst_q    <= BURST_FIXED;
            err_q      <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (awvalid && awready) begin
                        bid        <= awid;
                        cur_addr   <= awaddr;
                        len_q      <= awlen;
                        size_q     <= awsize;
                        burst_q    <= awburst;
                        wrap_lower <= aw_lower_c;
                        wrap_upper <= aw_lower_c + aw_total_c;
                        beat_q     <= '0;
                        err_q      <= aw_err_c;
                        awready    <= 1'b0;
                        wready     <= 1'b1;
                        state      <= ST_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_hs_c) begin
                        err_q    <= beat_err_c;
                        cur_addr <= next_addr_c;
                        if (last_beat_c) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bresp  <= beat_err_c;
                            state  <= ST_RESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                ST_RESP: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    awready <= 1'b0;
                    wready  <= 1'b0;
                    bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane memory write; contents survive reset
    always_ff @(posedge aclk) begin
        if (mem_we_c) begin
            for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                if (wstrb[i]) begin
                    mem[mem_base_c + MEM_ADDR_BITS'(i)] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Debug read port
    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_axi4_slave_write_ctrl.sv
// Self-checking bench for axi4_slave_write_ctrl: expected B responses go into a
// scoreboard queue when a burst is issued and are popped when B appears.
module tb_axi4_slave_write_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [15:0] bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] dbg_addr;
    logic [7:0]  dbg_rdata;

    typedef struct packed {
        logic [15:0] id;
        logic [1:0]  resp;
    } bexp_t;

    bexp_t       sb[$];
    logic [31:0] wd[256];
    logic [3:0]  ws[256];
    int          checks = 0;
    int          errors = 0;

    axi4_slave_write_ctrl #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .MEM_ADDR_BITS(12)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .awid     (awid),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .awsize   (awsize),
        .awburst  (awburst),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .bid      (bid),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .dbg_addr (dbg_addr),
        .dbg_rdata(dbg_rdata)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    // Issue one burst, drive all beats, then consume and check the B response.
    task automatic run_burst(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int bad_beat, input int hold_b);
        int    n;
        bexp_t e;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL aw_timeout awready=%b required=1", awready); end
        @(negedge aclk);
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL w_latency wready=%b required=1", wready); end
        for (int k = 0; k <= int'(len); k++) begin
            wdata = wd[k]; wstrb = ws[k];
            wlast = (k == int'(len)) ^ (k == bad_beat);
            wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
            if (n >= 100) begin
                checks++; errors++;
                $display("FAIL w_timeout beat=%0d wready=%b required=1", k, wready);
                break;
            end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL b_latency bvalid=%b required=1", bvalid); end
        for (int c = 0; c < hold_b; c++) begin
            @(negedge aclk);
            checks++;
            if (bvalid !== 1'b1 || bid !== sb[0].id || bresp !== sb[0].resp) begin
                errors++;
                $display("FAIL b_stable cycle=%0d bvalid=%b bid=%h bresp=%b required 1 %h %b",
                         c, bvalid, bid, bresp, sb[0].id, sb[0].resp);
            end
        end
        n = 0;
        while (bvalid !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
        e = sb.pop_front();
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL b_timeout bvalid=%b required=1", bvalid);
        end else begin
            checks++;
            if (bid !== e.id || bresp !== e.resp) begin
                errors++;
                $display("FAIL b_resp bid=%h bresp=%b required bid=%h bresp=%b", bid, bresp, e.id, e.resp);
            end
            bready = 1'b1;
            @(negedge aclk);
            bready = 1'b0;
            checks++;
            if (bvalid !== 1'b0 || awready !== 1'b1) begin
                errors++;
                $display("FAIL b_release bvalid=%b awready=%b required 0 1", bvalid, awready);
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; dbg_addr = '0;
        repeat (3) @(negedge aclk);
        checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || bid !== 16'h0 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs awready=%b wready=%b bvalid=%b bid=%h bresp=%b required all 0",
                     awready, wready, bvalid, bid, bresp);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (awready !== 1'b1 || wready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release awready=%b wready=%b required 1 0", awready, wready);
        end
    endtask

    task automatic test_single_beat();
        logic [31:0] pre_addr [3] = '{32'h000, 32'h200, 32'h300};
        logic [7:0]  pre_byte [3] = '{8'h55, 8'hFF, 8'h77};
        for (int t = 0; t < 3; t++) begin
            wd[0] = {4{pre_byte[t]}}; ws[0] = 4'hF;
            sb.push_back('{id: 16'h0A00 + 16'(t), resp: 2'b00});
            run_burst(16'h0A00 + 16'(t), pre_addr[t], 8'd0, 3'd2, 2'b01, -1, 0);
        end
        for (int t = 0; t < 3; t++) begin
            dbg_addr = 12'(pre_addr[t] + 32'd3); #1;
            checks++;
            if (dbg_rdata !== pre_byte[t]) begin
                errors++;
                $display("FAIL single_mem addr=%h got=%h required=%h", dbg_addr, dbg_rdata, pre_byte[t]);
            end
        end
    endtask

    task automatic test_incr();
        logic [31:0] exp_word;
        for (int k = 0; k < 4; k++) begin wd[k] = 32'h11223344 + 32'(k); ws[k] = 4'hF; end
        sb.push_back('{id: 16'h1234, resp: 2'b00});
        run_burst(16'h1234, 32'h100, 8'd3, 3'd2, 2'b01, -1, 0);
        for (int k = 0; k < 4; k++) begin
            exp_word = 32'h11223344 + 32'(k);
            for (int j = 0; j < 4; j++) begin
                dbg_addr = 12'(32'h100 + 32'(4 * k + j)); #1;
                checks++;
                if (dbg_rdata !== exp_word[8*j +: 8]) begin
                    errors++;
                    $display("FAIL incr_mem addr=%h got=%h required=%h", dbg_addr, dbg_rdata, exp_word[8*j +: 8]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] beat_addr [4] = '{12'h108, 12'h10C, 12'h100, 12'h104};
        logic [31:0] exp_word;
        for (int k = 0; k < 4; k++) begin wd[k] = 32'hA0A0A000 + 32'(k); ws[k] = 4'hF; end
        sb.push_back('{id: 16'h2222, resp: 2'b00});
        run_burst(16'h2222, 32'h108, 8'd3, 3'd2, 2'b10, -1, 0);
        for (int k = 0; k < 4; k++) begin
            exp_word = 32'hA0A0A000 + 32'(k);
            for (int j = 0; j < 4; j++) begin
                dbg_addr = beat_addr[k] + 12'(j); #1;
                checks++;
                if (dbg_rdata !== exp_word[8*j +: 8]) begin
                    errors++;
                    $display("FAIL wrap_mem addr=%h got=%h required=%h", dbg_addr, dbg_rdata, exp_word[8*j +: 8]);
                end
            end
        end
    endtask

    task automatic test_fixed_strobe();
        logic [7:0] exp_b [4] = '{8'h80, 8'h91, 8'hA2, 8'hFF};
        for (int k = 0; k < 3; k++) begin
            wd[k] = 32'h83828180 + 32'h10101010 * 32'(k);
            ws[k] = 4'(1 << k);
        end
        sb.push_back('{id: 16'h3333, resp: 2'b00});
        run_burst(16'h3333, 32'h200, 8'd2, 3'd2, 2'b00, -1, 0);
        for (int j = 0; j < 4; j++) begin
            dbg_addr = 12'h200 + 12'(j); #1;
            checks++;
            if (dbg_rdata !== exp_b[j]) begin
                errors++;
                $display("FAIL fixed_mem addr=%h got=%h required=%h", dbg_addr, dbg_rdata, exp_b[j]);
            end
        end
    endtask

    task automatic test_decerr();
        logic [7:0] exp_b [5] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h55};
        logic [11:0] chk_a [5] = '{12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF, 12'h000};
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        wd[1] = 32'h12345678; ws[1] = 4'hF;
        sb.push_back('{id: 16'h4444, resp: 2'b11});
        run_burst(16'h4444, 32'hFFC, 8'd1, 3'd2, 2'b01, -1, 0);
        for (int j = 0; j < 5; j++) begin
            dbg_addr = chk_a[j]; #1;
            checks++;
            if (dbg_rdata !== exp_b[j]) begin
                errors++;
                $display("FAIL decerr_mem addr=%h got=%h required=%h", dbg_addr, dbg_rdata, exp_b[j]);
            end
        end
    endtask

    task automatic test_slverr();
        for (int k = 0; k < 4; k++) begin wd[k] = 32'hDEAD0000 + 32'(k); ws[k] = 4'hF; end
        sb.push_back('{id: 16'h5550, resp: 2'b10});
        run_burst(16'h5550, 32'h300, 8'd1, 3'd2, 2'b11, -1, 0);
        dbg_addr = 12'h300; #1;
        checks++;
        if (dbg_rdata !== 8'h77) begin
            errors++; $display("FAIL resv_nowrite got=%h required=77", dbg_rdata);
        end
        sb.push_back('{id: 16'h5551, resp: 2'b10});
        run_burst(16'h5551, 32'h900, 8'd0, 3'd3, 2'b01, -1, 0);
        sb.push_back('{id: 16'h5552, resp: 2'b10});
        run_burst(16'h5552, 32'h400, 8'd3, 3'd2, 2'b01, 1, 0);
        dbg_addr = 12'h400; #1;
        checks++;
        if (dbg_rdata !== 8'h00) begin
            errors++; $display("FAIL wlast_beat0 got=%h required=00", dbg_rdata);
        end
    endtask

    task automatic test_backpressure();
        wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
        sb.push_back('{id: 16'hBEEF, resp: 2'b00});
        run_burst(16'hBEEF, 32'h500, 8'd0, 3'd2, 2'b01, -1, 10);
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] exp_b [2] = '{8'h61, 8'h62};
        @(negedge aclk);
        awid = 16'h6666; awaddr = 32'h600; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
        @(negedge aclk);
        awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wdata = {4{8'h61 + 8'(k)}}; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            @(negedge aclk);
        end
        wvalid = 1'b0;
        aresetn = 1'b0; #1;
        checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || bid !== 16'h0 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL midreset_outputs awready=%b wready=%b bvalid=%b bid=%h bresp=%b required all 0",
                     awready, wready, bvalid, bid, bresp);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL midreset_release awready=%b bvalid=%b required 1 0", awready, bvalid);
        end
        for (int k = 0; k < 2; k++) begin
            dbg_addr = 12'h600 + 12'(4 * k); #1;
            checks++;
            if (dbg_rdata !== exp_b[k]) begin
                errors++; $display("FAIL midreset_partial addr=%h got=%h required=%h", dbg_addr, dbg_rdata, exp_b[k]);
            end
        end
        wd[0] = 32'h70707070; ws[0] = 4'hF;
        sb.push_back('{id: 16'h7777, resp: 2'b00});
        run_burst(16'h7777, 32'h700, 8'd0, 3'd2, 2'b01, -1, 0);
    endtask

    task automatic test_back_to_back();
        int probe [4] = '{0, 1, 130, 255};
        for (int k = 0; k < 256; k++) begin wd[k] = {4{8'(k)}}; ws[k] = 4'(1 << (k % 4)); end
        sb.push_back('{id: 16'h8888, resp: 2'b00});
        run_burst(16'h8888, 32'h800, 8'd255, 3'd0, 2'b01, -1, 0);
        for (int j = 0; j < 4; j++) begin
            dbg_addr = 12'h800 + 12'(probe[j]); #1;
            checks++;
            if (dbg_rdata !== 8'(probe[j])) begin
                errors++; $display("FAIL long_incr addr=%h got=%h required=%h", dbg_addr, dbg_rdata, 8'(probe[j]));
            end
        end
        wd[0] = 32'h99999999; ws[0] = 4'hF;
        wd[1] = 32'h9A9A9A9A; ws[1] = 4'hF;
        sb.push_back('{id: 16'h9001, resp: 2'b00});
        run_burst(16'h9001, 32'hA00, 8'd1, 3'd2, 2'b01, -1, 0);
        sb.push_back('{id: 16'h9002, resp: 2'b00});
        run_burst(16'h9002, 32'hA08, 8'd1, 3'd2, 2'b01, -1, 0);
        dbg_addr = 12'hA0C; #1;
        checks++;
        if (dbg_rdata !== 8'h9A) begin
            errors++; $display("FAIL b2b_mem got=%h required=9a", dbg_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_incr();
        test_wrap();
        test_fixed_strobe();
        test_decerr();
        test_slverr();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
